ex_mem_buffer: RTL and testbench
================================

Name: ex_mem_buffer

Overview:
- Elastic EX/MEM pipeline stage. It sits directly downstream of the ALU in the RISC-V datapath.
- Captures ALUResult together with store data, destination register and memory/writeback control.
- Resolves branch-taken from the ALU Equal result.
- Presents the bundle to the MEM stage through a valid/ready handshake. A 2-entry skid buffer (output register plus skid register) removes any combinational ready path from MEM back to EX.

Parameters:
- DATA_WIDTH, 32, width of ALUResult and store data
- REG_ADDR_WIDTH, 5, destination register index width

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- flush  in  1  synchronous pipeline flush (branch mispredict or trap)
- ex_valid  in  1  EX presents a valid bundle
- ex_ready  out  1  buffer can accept a bundle this cycle
- ALUResult  in  DATA_WIDTH  result from ALU
- StoreData  in  DATA_WIDTH  rs2 value for stores
- rd  in  REG_ADDR_WIDTH  destination register
- MemRead, MemWrite, RegWrite, MemtoReg, Branch  in  1 each  control bits from ID/EX
- mem_valid  out  1  output bundle valid
- mem_ready  in  1  MEM consumes the bundle this cycle
- mem_ALUResult, mem_StoreData  out  DATA_WIDTH  registered payload
- mem_rd  out  REG_ADDR_WIDTH  registered rd
- mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg  out  1 each  registered control
- mem_BrTaken  out  1  registered branch decision

Behaviour:
- Reset: clk and reset only; synchronous, active-low. reset==0 at a rising edge clears mem_valid, the skid-full flag and every mem_* output to 0. ex_ready reads 1 in the first cycle after reset.
- Transfer-in: fires when ex_valid && ex_ready. Transfer-out: fires when mem_valid && mem_ready.
- ex_ready = !skid_full. It is a direct function of a register, with no combinational dependence on mem_ready or ex_valid.
- Capture transform, applied when a bundle enters either register:
  - BrTaken = Branch & ALUResult[0]. ALU Equal returns 1 or 0 in bit 0.
  - RegWrite is forced to 0 when rd==0.
  - All other fields pass through unchanged.
- Output register update, when it is empty or its bundle is leaving this cycle:
  - Skid full: load from skid and clear skid. If a transfer-in also fires, the incoming bundle goes into skid.
  - Skid empty and transfer-in fires: load the incoming bundle.
  - Otherwise: mem_valid goes to 0.
- Output register holding, not leaving: a transfer-in writes the skid register and sets skid_full.
- Latency: 1 cycle from transfer-in to mem_valid when the buffer is empty.
- Throughput: 1 bundle/cycle while mem_ready==1.
- Ordering: strictly FIFO. Bundles are never dropped or duplicated except on flush.
- Stall stability: while mem_valid && !mem_ready, all mem_* outputs hold their values.
- Flush, on a rising edge with reset==1:
  - mem_valid and skid_full go to 0.
  - Any same-cycle transfer-in is discarded.
  - mem_* payload values are don't-care but must not change mem_valid.
  - Reset has priority over flush.
- Full condition: both registers occupied and mem_ready==0. ex_ready is 0 and ex_valid is ignored.
- The skid register is written only when ex_ready==1, so no overwrite is possible.
- Reset mid-stall: contents are lost and the state matches post-reset.

Test Plan:
- Reset: hold reset=0 for 2 cycles with ex_valid=1 -> mem_valid=0, all mem_* outputs 0. Release: ex_ready=1 the next cycle.
- Single pass-through: ex_valid=1, ALUResult=0x0000_00A5, rd=7, RegWrite=1, mem_ready=1 -> next cycle mem_valid=1, mem_ALUResult=0xA5, mem_rd=7, mem_RegWrite=1. With ex_valid=0 afterwards, mem_valid=0 one cycle later.
- Branch and x0:
  - Branch=1, ALUResult=1 -> mem_BrTaken=1.
  - Branch=1, ALUResult=0 -> mem_BrTaken=0.
  - rd=0, RegWrite=1 -> mem_RegWrite=0.
- Backpressure: stream values 1,2,3 with mem_ready=0 -> after 2 accepts ex_ready=0, mem_ALUResult holds 1. Raise mem_ready -> outputs 1,2,3 in order, no loss or duplicate, ex_ready=1 the cycle after skid drains.
- Flush: both registers full, assert flush with ex_valid=1, ALUResult=9 -> next cycle mem_valid=0, ex_ready=1, and 9 never appears at the output.
- Full-rate stream: mem_ready=1 and ex_valid=1 for 100 random bundles -> all 100 emerge in order, each 1 cycle after entry, ex_ready constantly 1.

Source files
------------

// File: rtl/ex_mem_buffer.sv
// EX/MEM elastic pipeline stage.
// The incoming ALU bundle is captured and handed to MEM over valid/ready.
// A skid register behind the output register absorbs one bundle when MEM
// stalls. Because of it, ex_ready depends only on a flop, so there is no
// combinational ready path from MEM back to EX.
module ex_mem_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [DATA_WIDTH-1:0]     ALUResult,
    input  logic [DATA_WIDTH-1:0]     StoreData,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      RegWrite,
    input  logic                      MemtoReg,
    input  logic                      Branch,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [DATA_WIDTH-1:0]     mem_ALUResult,
    output logic [DATA_WIDTH-1:0]     mem_StoreData,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd,
    output logic                      mem_MemRead,
    output logic                      mem_MemWrite,
    output logic                      mem_RegWrite,
    output logic                      mem_MemtoReg,
    output logic                      mem_BrTaken
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [DATA_WIDTH-1:0]     store_data;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      mem_read;
        logic                      mem_write;
        logic                      reg_write;
        logic                      mem_to_reg;
        logic                      br_taken;
    } bundle_t;

    bundle_t in_bundle;
    bundle_t out_reg;
    bundle_t out_next;
    bundle_t skid_reg;
    bundle_t skid_next;
    logic    out_valid_reg;
    logic    out_valid_next;
    logic    skid_full_reg;
    logic    skid_full_next;
    logic    xfer_in;
    logic    out_free;

    // Ready comes straight from the skid flag so that MEM stalls never ripple combinationally into EX.
    assign ex_ready = ~skid_full_reg;
    assign xfer_in  = ex_valid & ~skid_full_reg;
    // The output register may be reloaded when it is empty or its bundle leaves this cycle.
    assign out_free = ~out_valid_reg | mem_ready;

    // Capture transform: resolve the branch from ALU Equal (bit 0), and never write x0.
    always_comb begin
        in_bundle.alu_result = ALUResult;
        in_bundle.store_data = StoreData;
        in_bundle.rd         = rd;
        in_bundle.mem_read   = MemRead;
        in_bundle.mem_write  = MemWrite;
        in_bundle.reg_write  = RegWrite & (rd != '0);
        in_bundle.mem_to_reg = MemtoReg;
        in_bundle.br_taken   = Branch & ALUResult[0];
    end

    // Next-state for the output/skid pair. Flush discards everything, including a same-cycle input.
    always_comb begin
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        skid_next      = skid_reg;
        skid_full_next = skid_full_reg;
        if (out_free) begin
            if (skid_full_reg) begin
                out_next       = skid_reg;
                out_valid_next = 1'b1;
                skid_full_next = xfer_in;
                if (xfer_in) begin
                    skid_next = in_bundle;
                end
            end else if (xfer_in) begin
                out_next       = in_bundle;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (xfer_in) begin
            skid_next      = in_bundle;
            skid_full_next = 1'b1;
        end
        if (flush) begin
            out_valid_next = 1'b0;
            skid_full_next = 1'b0;
        end
    end

    // State registers. The active-low synchronous reset takes priority over flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            skid_reg      <= '0;
            skid_full_reg <= 1'b0;
        end else begin
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            skid_reg      <= skid_next;
            skid_full_reg <= skid_full_next;
        end
    end

    assign mem_valid     = out_valid_reg;
    assign mem_ALUResult = out_reg.alu_result;
    assign mem_StoreData = out_reg.store_data;
    assign mem_rd        = out_reg.rd;
    assign mem_MemRead   = out_reg.mem_read;
    assign mem_MemWrite  = out_reg.mem_write;
    assign mem_RegWrite  = out_reg.reg_write;
    assign mem_MemtoReg  = out_reg.mem_to_reg;
    assign mem_BrTaken   = out_reg.br_taken;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Scoreboard bench for ex_mem_buffer.
// Accepted bundles are queued with their expected MEM-side view. A separate
// monitor pops the queue on every transfer-out and compares the fields.
module tb_ex_mem_buffer;

    logic        clk = 1'b0;
    logic        reset, flush, ex_valid, ex_ready, mem_valid, mem_ready;
    logic [31:0] ALUResult, StoreData, mem_ALUResult, mem_StoreData;
    logic [4:0]  rd, mem_rd;
    logic        MemRead, MemWrite, RegWrite, MemtoReg, Branch;
    logic        mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg, mem_BrTaken;

    ex_mem_buffer #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ALUResult(ALUResult), .StoreData(StoreData), .rd(rd),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .Branch(Branch),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_ALUResult(mem_ALUResult), .mem_StoreData(mem_StoreData), .mem_rd(mem_rd),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_RegWrite(mem_RegWrite),
        .mem_MemtoReg(mem_MemtoReg), .mem_BrTaken(mem_BrTaken)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [4:0]  ctrl;   // {MemRead, MemWrite, RegWrite, MemtoReg, BrTaken}
        logic [31:0] stamp;
        logic [31:0] lat;    // 0 = latency not checked
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic        exp_br, exp_rw;
    logic [31:0] exp_lat;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] r,
                          input logic mr, input logic mw, input logic rw, input logic m2r,
                          input logic br, input logic ebr, input logic erw, input logic [31:0] lat);
        ex_valid = 1'b1; ALUResult = alu; StoreData = sd; rd = r;
        MemRead = mr; MemWrite = mw; RegWrite = rw; MemtoReg = m2r; Branch = br;
        exp_br = ebr; exp_rw = erw; exp_lat = lat;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Issue side: a transfer-in that will land at the next edge pushes its expected bundle.
    always @(negedge clk) begin
        if (reset && !flush && ex_valid && ex_ready) begin
            sb_q.push_back('{alu: ALUResult, sd: StoreData, rd: rd,
                             ctrl: {MemRead, MemWrite, exp_rw, MemtoReg, exp_br},
                             stamp: cyc, lat: exp_lat});
            $display("cycle %0d: issue alu=%08h rd=%0d", cyc, ALUResult, rd);
        end
    end

    // Monitor: every transfer-out must match the oldest expected bundle.
    always @(negedge clk) begin
        exp_t e;
        if (reset && mem_valid && mem_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", {48'd0, mem_ALUResult}, 80'hdead_0000);
            end else begin
                e = sb_q.pop_front();
                $display("cycle %0d: mem alu=%08h rd=%0d ctrl=%05b", cyc, mem_ALUResult, mem_rd,
                         {mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg, mem_BrTaken});
                chk("out_data", {16'd0, mem_ALUResult, mem_StoreData}, {16'd0, e.alu, e.sd});
                chk("out_ctrl", {70'd0, mem_rd, mem_MemRead, mem_MemWrite, mem_RegWrite,
                                 mem_MemtoReg, mem_BrTaken}, {70'd0, e.rd, e.ctrl});
                if (e.lat != 0) chk("latency", 80'(cyc - e.stamp), 80'(e.lat));
            end
        end
    end

    // Stall stability: a stalled bundle must be held unchanged across the edge.
    logic        stall_prev = 1'b0;
    logic [73:0] snap;
    always @(negedge clk) begin
        if (stall_prev) begin
            chk("stall_hold", {5'd0, mem_valid, mem_ALUResult, mem_StoreData, mem_rd,
                               mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg, mem_BrTaken},
                {5'd0, 1'b1, snap});
        end
        stall_prev = reset && !flush && mem_valid && !mem_ready;
        snap = {mem_ALUResult, mem_StoreData, mem_rd, mem_MemRead, mem_MemWrite,
                mem_RegWrite, mem_MemtoReg, mem_BrTaken};
    end

    initial begin
        reset = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        set_in(32'hFFFF_FFFF, 32'h1234_5678, 5'd9, 1, 1, 1, 1, 1, 1, 1, 0);

        // Reset held for two cycles with ex_valid high.
        step(); step();
        chk("reset_valid", 80'(mem_valid), 80'd0);
        chk("reset_outs", {6'd0, mem_ALUResult, mem_StoreData, mem_rd, mem_MemRead, mem_MemWrite,
                           mem_RegWrite, mem_MemtoReg, mem_BrTaken}, 80'd0);
        reset = 1'b1; ex_valid = 1'b0;
        step();
        chk("ready_after_reset", 80'(ex_ready), 80'd1);

        // Single pass-through, then idle.
        mem_ready = 1'b1;
        set_in(32'h0000_00A5, 32'h0000_1111, 5'd7, 0, 0, 1, 0, 0, 0, 1, 1);
        step();
        ex_valid = 1'b0;
        chk("pass_valid", 80'(mem_valid), 80'd1);
        step();
        chk("idle_valid", 80'(mem_valid), 80'd0);

        // Branch resolution and x0 write suppression, back to back.
        set_in(32'h0000_0001, 32'h0, 5'd3, 0, 0, 0, 0, 1, 1, 0, 1); step();
        set_in(32'h0000_0000, 32'h0, 5'd4, 0, 0, 0, 0, 1, 0, 0, 1); step();
        set_in(32'h0000_0003, 32'h0, 5'd5, 0, 0, 0, 0, 0, 0, 0, 1); step();
        set_in(32'h0000_0040, 32'hCAFE, 5'd0, 1, 0, 1, 1, 0, 0, 0, 1); step();
        set_in(32'h0000_0080, 32'hBEEF, 5'd31, 0, 1, 1, 0, 0, 0, 1, 1); step();
        ex_valid = 1'b0;
        step();

        // Backpressure: values 1, 2, 3 while MEM stalls.
        mem_ready = 1'b0;
        set_in(32'd1, 32'h0, 5'd1, 0, 0, 1, 0, 0, 0, 1, 0); step();
        set_in(32'd2, 32'h0, 5'd2, 0, 0, 1, 0, 0, 0, 1, 0); step();
        set_in(32'd3, 32'h0, 5'd3, 0, 0, 1, 0, 0, 0, 1, 0);
        chk("full_ready", 80'(ex_ready), 80'd0);
        chk("full_head", 80'(mem_ALUResult), 80'd1);
        step();
        chk("full_ready_hold", 80'(ex_ready), 80'd0);
        mem_ready = 1'b1;
        step();
        chk("ready_after_drain", 80'(ex_ready), 80'd1);
        step();
        ex_valid = 1'b0;
        step(); step();
        chk("bp_empty", 80'(mem_valid), 80'd0);
        chk("bp_queue", 80'(sb_q.size()), 80'd0);

        // Flush with both registers full (incoming 9 is blocked).
        mem_ready = 1'b0;
        set_in(32'd5, 32'h0, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_in(32'd6, 32'h0, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_in(32'd9, 32'h0, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        step();
        flush = 1'b0; ex_valid = 1'b0;
        sb_q.delete();
        chk("flush_valid", 80'(mem_valid), 80'd0);
        chk("flush_ready", 80'(ex_ready), 80'd1);

        // Flush with only the output full: the same-cycle 9 must be discarded.
        set_in(32'd5, 32'h0, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_in(32'd9, 32'h0, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        step();
        flush = 1'b0; ex_valid = 1'b0;
        sb_q.delete();
        chk("flush2_valid", 80'(mem_valid), 80'd0);
        chk("flush2_ready", 80'(ex_ready), 80'd1);
        mem_ready = 1'b1;
        step(); step();
        chk("flush_no_leak", 80'(mem_valid), 80'd0);

        // Reset in the middle of a full stall.
        mem_ready = 1'b0;
        set_in(32'd7, 32'h0, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();
        ex_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        sb_q.delete();
        chk("midreset_valid", 80'(mem_valid), 80'd0);
        chk("midreset_ready", 80'(ex_ready), 80'd1);

        // Full-rate stream of 100 random bundles.
        mem_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [31:0] a;
            logic [4:0]  r;
            logic        b, w;
            a = $urandom; r = 5'($urandom_range(0, 31));
            b = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
            set_in(a, $urandom, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w,
                   1'($urandom_range(0, 1)), b, b & a[0], w & (r != 5'd0), 1);
            chk("stream_ready", 80'(ex_ready), 80'd1);
            step();
        end
        ex_valid = 1'b0;
        step(); step();
        chk("final_queue", 80'(sb_q.size()), 80'd0);
        chk("final_valid", 80'(mem_valid), 80'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
